spi_flash_ctrl: RTL and testbench

//  Operation sequencer that sits directly upstream of spi_master and drives its user interface.

---
 rtl/spi_flash_ctrl_if.sv | 40 ++++
 rtl/spi_flash_ctrl.sv | 160 ++++++++++++++++
 tb/tb_spi_flash_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_ctrl_if.sv
// User-request and spi_master-facing signals of the flash operation sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface spi_flash_ctrl_if #(
   parameter int ADDR_WIDTH = 24
);
   logic                  op_start;
   logic [1:0]            op_type;
   logic [ADDR_WIDTH-1:0] op_addr;
   logic [11:0]           op_len;
   logic                  op_busy;
   logic                  op_done;
   logic                  op_err;
   logic                  usr_wr_req;
   logic [7:0]            usr_wr_data;
   logic [7:0]            usr_rd_data;
   logic                  usr_rd_vld;
   logic                  spi_start;
   logic [7:0]            spi_cmd;
   logic [ADDR_WIDTH-1:0] spi_addr;
   logic [11:0]           spi_length;
   logic [7:0]            spi_wr_data;
   logic [7:0]            spi_rd_data;
   logic                  spi_busy;
   logic                  spi_wr_req;
   logic                  spi_rd_vld;

   modport master (
      output op_start, op_type, op_addr, op_len, usr_wr_data,
             spi_rd_data, spi_busy, spi_wr_req, spi_rd_vld,
      input  op_busy, op_done, op_err, usr_wr_req, usr_rd_data, usr_rd_vld,
             spi_start, spi_cmd, spi_addr, spi_length, spi_wr_data
   );

   modport slave (
      input  op_start, op_type, op_addr, op_len, usr_wr_data,
             spi_rd_data, spi_busy, spi_wr_req, spi_rd_vld,
      output op_busy, op_done, op_err, usr_wr_req, usr_rd_data, usr_rd_vld,
             spi_start, spi_cmd, spi_addr, spi_length, spi_wr_data
   );
endinterface

// File: rtl/spi_flash_ctrl.sv
// Sequences READ / PROGRAM / ERASE into WREN, command and RDSR-poll frames for spi_master.
// Frames start one cycle after the *_S state; data bytes are paced entirely by spi_master.
module spi_flash_ctrl #(
   parameter int          ADDR_WIDTH = 24,
   parameter logic [7:0]  CMD_READ   = 8'h03,
   parameter logic [7:0]  CMD_PP     = 8'h02,
   parameter logic [7:0]  CMD_SE     = 8'hD8,
   parameter logic [7:0]  CMD_WREN   = 8'h06,
   parameter logic [7:0]  CMD_RDSR   = 8'h05,
   parameter logic [15:0] POLL_MAX   = 16'd50000
) (
   input logic             clk,
   input logic             rst,
   spi_flash_ctrl_if.slave bus
);
   typedef enum logic [3:0] {
      IDLE, WREN_S, WREN_W, CMD_S, CMD_W, POLL_S, POLL_W, POLL_CHK, DONE
   } state_t;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_PROG  = 2'b01;
   localparam logic [1:0] OP_ERASE = 2'b10;

   state_t                state;
   logic [1:0]            type_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [11:0]           len_q;
   logic                  busy_seen;
   logic                  wip;
   logic [15:0]           poll_cnt;
   logic                  reject;
   logic                  frame_end;
   logic [7:0]            cmd_op;

   always_comb begin
      reject = (bus.op_type == 2'b11)
            || (bus.op_len == 12'd0 && bus.op_type != OP_ERASE)
            || (bus.op_len > 12'd256 && bus.op_type == OP_PROG);
   end

   always_comb begin
      cmd_op = CMD_READ;
      case (type_q)
         OP_PROG:  cmd_op = CMD_PP;
         OP_ERASE: cmd_op = CMD_SE;
         default:  cmd_op = CMD_READ;
      endcase
   end

   // A frame is over only once busy has been seen high and then falls.
   assign frame_end       = busy_seen && !bus.spi_busy;
   assign bus.usr_wr_req  = bus.spi_wr_req && (state == CMD_W) && (type_q == OP_PROG);
   assign bus.spi_wr_data = bus.usr_wr_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         type_q          <= '0;
         addr_q          <= '0;
         len_q           <= '0;
         busy_seen       <= 1'b0;
         wip             <= 1'b0;
         poll_cnt        <= '0;
         bus.op_busy     <= 1'b0;
         bus.op_done     <= 1'b0;
         bus.op_err      <= 1'b0;
         bus.usr_rd_vld  <= 1'b0;
         bus.usr_rd_data <= '0;
         bus.spi_start   <= 1'b0;
         bus.spi_cmd     <= '0;
         bus.spi_addr    <= '0;
         bus.spi_length  <= '0;
      end else begin
         bus.spi_start  <= 1'b0;
         bus.op_done    <= 1'b0;
         bus.op_err     <= 1'b0;
         bus.usr_rd_vld <= 1'b0;
         if (state == CMD_W && type_q == OP_READ && bus.spi_rd_vld) begin
            bus.usr_rd_vld  <= 1'b1;
            bus.usr_rd_data <= bus.spi_rd_data;
         end
         case (state)
            IDLE: begin
               if (bus.op_start) begin
                  type_q   <= bus.op_type;
                  addr_q   <= bus.op_addr;
                  len_q    <= bus.op_len;
                  poll_cnt <= '0;
                  if (reject) begin
                     bus.op_done <= 1'b1;
                     bus.op_err  <= 1'b1;
                     state       <= DONE;
                  end else begin
                     bus.op_busy <= 1'b1;
                     state       <= (bus.op_type == OP_READ) ? CMD_S : WREN_S;
                  end
               end
            end
            WREN_S: begin
               bus.spi_start  <= 1'b1;
               bus.spi_cmd    <= CMD_WREN;
               bus.spi_addr   <= '0;
               bus.spi_length <= 12'd0;
               busy_seen      <= 1'b0;
               state          <= WREN_W;
            end
            WREN_W: begin
               if (bus.spi_busy) busy_seen <= 1'b1;
               if (frame_end)    state     <= CMD_S;
            end
            CMD_S: begin
               bus.spi_start  <= 1'b1;
               bus.spi_cmd    <= cmd_op;
               bus.spi_addr   <= addr_q;
               bus.spi_length <= (type_q == OP_ERASE) ? 12'd0 : len_q;
               busy_seen      <= 1'b0;
               state          <= CMD_W;
            end
            CMD_W: begin
               if (bus.spi_busy) busy_seen <= 1'b1;
               if (frame_end) begin
                  if (type_q == OP_READ) begin
                     bus.op_busy <= 1'b0;
                     bus.op_done <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= POLL_S;
                  end
               end
            end
            POLL_S: begin
               bus.spi_start  <= 1'b1;
               bus.spi_cmd    <= CMD_RDSR;
               bus.spi_addr   <= '0;
               bus.spi_length <= 12'd1;
               busy_seen      <= 1'b0;
               state          <= POLL_W;
            end
            POLL_W: begin
               if (bus.spi_busy)   busy_seen <= 1'b1;
               if (bus.spi_rd_vld) wip       <= bus.spi_rd_data[0];
               if (frame_end)      state     <= POLL_CHK;
            end
            POLL_CHK: begin
               if (wip && poll_cnt < POLL_MAX) begin
                  poll_cnt <= poll_cnt + 16'd1;
                  state    <= POLL_S;
               end else begin
                  bus.op_busy <= 1'b0;
                  bus.op_done <= 1'b1;
                  bus.op_err  <= wip;
                  state       <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Directed bench: behavioural spi_master/flash model plus user-side data source and monitors.
module tb_spi_flash_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_flash_ctrl_if #(.ADDR_WIDTH(24)) bus();

   spi_flash_ctrl #(.ADDR_WIDTH(24), .POLL_MAX(16'd3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Frame log and flash behaviour knobs
   int          n_frames  = 0;
   int          rdsr_cnt  = 0;
   int          wip_ones  = 0;
   bit          wip_stuck = 1'b0;
   logic [7:0]  log_cmd  [64];
   logic [23:0] log_addr [64];
   logic [11:0] log_len  [64];
   logic [7:0]  wr_seen  [8];
   int          wr_seen_n = 0;
   logic [7:0]  m_cmd;
   logic [11:0] m_len;
   logic [7:0]  m_status;

   // Monitors
   int         done_cnt   = 0;
   logic       last_err   = 1'b0;
   int         rd_cnt     = 0;
   logic [7:0] rd_buf [16];
   int         wr_req_cnt = 0;
   int         start_cnt  = 0;

   int f0, s0, d0, r0, w0, ws0, rc0, n;
   logic [1:0]  rj_type [3];
   logic [11:0] rj_len  [3];

   always @(negedge clk) begin
      if (bus.op_done) begin
         done_cnt = done_cnt + 1;
         last_err = bus.op_err;
      end
      if (bus.usr_rd_vld) begin
         if (rd_cnt < 16) rd_buf[rd_cnt] = bus.usr_rd_data;
         rd_cnt = rd_cnt + 1;
      end
      if (bus.usr_wr_req) wr_req_cnt = wr_req_cnt + 1;
      if (bus.spi_start)  start_cnt  = start_cnt + 1;
   end

   // spi_master + flash model
   initial begin
      bus.spi_busy = 1'b0; bus.spi_wr_req = 1'b0; bus.spi_rd_vld = 1'b0; bus.spi_rd_data = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (bus.spi_start && !rst) begin
            m_cmd = bus.spi_cmd;
            m_len = bus.spi_length;
            if (n_frames < 64) begin
               log_cmd[n_frames]  = bus.spi_cmd;
               log_addr[n_frames] = bus.spi_addr;
               log_len[n_frames]  = bus.spi_length;
            end
            n_frames = n_frames + 1;
            if (m_cmd == 8'h05) rdsr_cnt = rdsr_cnt + 1;
            @(posedge clk); #1;
            bus.spi_busy = 1'b1;
            for (int i = 0; i < int'(m_len); i++) begin
               if (m_cmd == 8'h02) begin
                  bus.spi_wr_req = 1'b1;
                  @(posedge clk); #1;
                  bus.spi_wr_req = 1'b0;
                  @(negedge clk);
                  if (wr_seen_n < 8) wr_seen[wr_seen_n] = bus.spi_wr_data;
                  wr_seen_n = wr_seen_n + 1;
                  @(posedge clk); #1;
               end else begin
                  if (m_cmd == 8'h05) begin
                     m_status = (wip_stuck || wip_ones > 0) ? 8'h01 : 8'h00;
                     if (wip_ones > 0) wip_ones = wip_ones - 1;
                     bus.spi_rd_data = m_status;
                  end else begin
                     bus.spi_rd_data = 8'(16 + i);
                  end
                  bus.spi_rd_vld = 1'b1;
                  @(posedge clk); #1;
                  bus.spi_rd_vld = 1'b0;
                  @(posedge clk); #1;
               end
            end
            @(posedge clk); #1;
            bus.spi_busy = 1'b0;
         end
      end
   end

   // User write-data source: byte appears one clock after usr_wr_req
   logic [7:0] wr_bytes [2];
   int         wr_idx = 0;
   initial begin
      wr_bytes[0] = 8'hA5;
      wr_bytes[1] = 8'h5A;
      bus.usr_wr_data = 8'h00;
      forever begin
         @(posedge clk);
         if (bus.usr_wr_req) begin
            #1;
            bus.usr_wr_data = wr_bytes[wr_idx];
            wr_idx = (wr_idx + 1) % 2;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [1:0] t, input logic [23:0] a, input logic [11:0] l);
      bus.op_type  = t;
      bus.op_addr  = a;
      bus.op_len   = l;
      bus.op_start = 1'b1;
      @(posedge clk); #1;
      bus.op_start = 1'b0;
   endtask

   task automatic wait_done(input int prev);
      int k = 0;
      while (done_cnt == prev && k < 4000) begin
         @(posedge clk); #1;
         k++;
      end
      chk("done_seen", 64'(done_cnt > prev), 64'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.op_start = 1'b0; bus.op_type = 2'b00; bus.op_addr = 24'h0; bus.op_len = 12'h0;
      rj_type[0] = 2'b01; rj_len[0] = 12'd257;
      rj_type[1] = 2'b00; rj_len[1] = 12'd0;
      rj_type[2] = 2'b11; rj_len[2] = 12'd5;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs",
          {bus.op_busy, bus.op_done, bus.op_err, bus.usr_wr_req, bus.usr_rd_vld, bus.usr_rd_data,
           bus.spi_start, bus.spi_cmd, bus.spi_addr, bus.spi_length}, 64'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // 1: READ
      f0 = n_frames; s0 = start_cnt; d0 = done_cnt; r0 = rd_cnt;
      start_op(2'b00, 24'h001234, 12'd4);
      chk("read_busy", bus.op_busy, 1);
      wait_done(d0);
      chk("read_starts", start_cnt - s0, 1);
      chk("read_cmd",  log_cmd[f0],  8'h03);
      chk("read_addr", log_addr[f0], 24'h001234);
      chk("read_len",  log_len[f0],  12'd4);
      chk("read_vld_cnt", rd_cnt - r0, 4);
      chk("read_byte0", rd_buf[r0], 8'h10);
      chk("read_byte3", rd_buf[r0 + 3], 8'h13);
      chk("read_err", last_err, 0);
      chk("read_busy_end", bus.op_busy, 0);

      // 2: PROGRAM with two busy polls
      f0 = n_frames; d0 = done_cnt; w0 = wr_req_cnt; ws0 = wr_seen_n; rc0 = rdsr_cnt;
      wip_ones = 2;
      start_op(2'b01, 24'h000100, 12'd2);
      wait_done(d0);
      chk("pp_frames", n_frames - f0, 5);
      chk("pp_cmd_seq", {log_cmd[f0], log_cmd[f0 + 1], log_cmd[f0 + 2], log_cmd[f0 + 3], log_cmd[f0 + 4]},
          40'h06_02_05_05_05);
      chk("pp_wren_len", log_len[f0], 0);
      chk("pp_cmd_addr", log_addr[f0 + 1], 24'h000100);
      chk("pp_cmd_len", log_len[f0 + 1], 12'd2);
      chk("pp_rdsr_len", log_len[f0 + 2], 12'd1);
      chk("pp_rdsr_cnt", rdsr_cnt - rc0, 3);
      chk("pp_wr_req_cnt", wr_req_cnt - w0, 2);
      chk("pp_bytes", {wr_seen[ws0], wr_seen[ws0 + 1]}, 16'hA55A);
      chk("pp_err", last_err, 0);

      // 3: ERASE with WIP stuck, POLL_MAX=3
      f0 = n_frames; d0 = done_cnt; rc0 = rdsr_cnt;
      wip_stuck = 1'b1;
      start_op(2'b10, 24'h010000, 12'd0);
      wait_done(d0);
      wip_stuck = 1'b0;
      chk("se_cmd", log_cmd[f0 + 1], 8'hD8);
      chk("se_len", log_len[f0 + 1], 12'd0);
      chk("se_rdsr_cnt", rdsr_cnt - rc0, 4);
      chk("se_err", last_err, 1);

      // 4: rejects
      for (int j = 0; j < 3; j++) begin
         s0 = start_cnt; d0 = done_cnt;
         start_op(rj_type[j], 24'h000000, rj_len[j]);
         chk("rej_done_err", {bus.op_done, bus.op_err, bus.op_busy}, 3'b110);
         repeat (6) @(posedge clk);
         #1;
         chk("rej_no_start", start_cnt - s0, 0);
         chk("rej_done_cnt", done_cnt - d0, 1);
      end

      // 5: op_start while busy is ignored
      f0 = n_frames; s0 = start_cnt; d0 = done_cnt;
      start_op(2'b00, 24'h000200, 12'd4);
      repeat (4) @(posedge clk);
      #1;
      start_op(2'b00, 24'h000055, 12'd2);
      wait_done(d0);
      repeat (20) @(posedge clk);
      #1;
      chk("busy_starts", start_cnt - s0, 1);
      chk("busy_done_cnt", done_cnt - d0, 1);
      chk("busy_addr", log_addr[f0], 24'h000200);

      // 6: reset during RDSR polling
      rc0 = rdsr_cnt;
      wip_stuck = 1'b1;
      start_op(2'b01, 24'h000300, 12'd1);
      n = 0;
      while (!(rdsr_cnt > rc0 && bus.spi_busy) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("poll_reached", 64'(rdsr_cnt > rc0), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_outputs",
          {bus.op_busy, bus.op_done, bus.op_err, bus.usr_wr_req, bus.usr_rd_vld, bus.usr_rd_data,
           bus.spi_start, bus.spi_cmd, bus.spi_addr, bus.spi_length}, 64'd0);
      rst = 1'b0;
      s0 = start_cnt;
      repeat (20) @(posedge clk);
      #1;
      wip_stuck = 1'b0;
      chk("midrst_no_start", start_cnt - s0, 0);
      f0 = n_frames; d0 = done_cnt; r0 = rd_cnt;
      start_op(2'b00, 24'h000ABC, 12'd2);
      wait_done(d0);
      chk("post_rst_cmd", {log_cmd[f0], log_addr[f0]}, {8'h03, 24'h000ABC});
      chk("post_rst_rd_cnt", rd_cnt - r0, 2);
      chk("post_rst_err", last_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
